float_multi_fp16: RTL and testbench
===================================

Name: float_multi_fp16

Overview:
- IEEE-754 binary16 (half-precision) multiplier with registered outputs.
- Takes two 16-bit operands {sign, 5-bit exponent, 10-bit fraction}, bias 15.
- Returns the rounded product plus status flags: overflow, zero, NaN, inexact.
- Used as the arithmetic leaf of the fixed/floating adder-multiplier datapath; one operation per clock, fully pipelined.

Parameters:
- none (format fixed at binary16)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- valid_in  input  1  operands valid this cycle
- num1  input  16  operand A {sign, exp[4:0], frac[9:0]}
- num2  input  16  operand B, same format
- valid_out  output  1  result/flags valid, valid_in delayed 1 cycle
- result  output  16  rounded binary16 product
- overflow  output  1  finite operands produced a magnitude beyond max normal; result is ±inf
- zero  output  1  result is ±0
- nan  output  1  result is NaN
- precisionLost  output  1  nonzero bits were discarded (inexact result)

Behaviour:
- Interface rule: one clock; reset is synchronous and active-low.
- Reset: while rst_n=0 at a clock edge, all outputs are cleared to 0 (valid_out, result, overflow, zero, nan, precisionLost).
- Latency: exactly 1 cycle.
  - Combinational compute from num1/num2, registered on the rising edge when valid_in=1.
  - Output registers hold their previous value when valid_in=0.
  - valid_out <= valid_in every cycle.
- Sign: sign1 XOR sign2 for all results, NaN excepted.
- Operand decode:
  - exp=0 is zero or subnormal (significand 0.f, effective exp −14).
  - exp=31 with frac=0 is infinity; exp=31 with frac≠0 is NaN.
  - Otherwise normal, significand 1.f.
- Specials, in priority order:
  - Any NaN operand, or 0×inf: result=16'h7E00, nan=1, other flags 0.
  - inf × nonzero: ±inf (exp=31, frac=0), overflow=0.
  - Zero operand (finite other): ±0, zero=1, precisionLost=0.
- Finite multiply:
  - 11×11-bit significand product (22 bits); exponent = eA + eB − 15.
  - Normalize using a leading-one search, so subnormal inputs are handled.
  - Result exponent ≥31: ±inf (16'h7C00 | sign), overflow=1, precisionLost=1.
  - Result exponent <1: right-shift into subnormal range, OR-ing shifted-out bits into a sticky bit.
- Rounding: round-to-nearest, ties-to-even, using guard + round + sticky bits.
  - Mantissa carry-out after rounding increments the exponent; this may reach inf (overflow=1).
  - A subnormal that rounds up to 0x400 becomes the smallest normal.
- precisionLost: 1 whenever any guard/round/sticky bit was nonzero (before rounding), or on overflow.
- zero: 1 when the final result magnitude is 0. This includes underflow to 0, which also sets precisionLost=1.
- All flags are mutually consistent with the result; the flags describe the same registered sample as result.

Test Plan:
- Normal, inexact: num1=16'h54A5, num2=16'h10CC -> result=16'h2992, precisionLost=1, other flags 0, valid_out one cycle after valid_in.
- Exact, mixed sign: num1=16'hC0B0, num2=16'h1CC0 -> 16'hA191, all flags 0. Second case: num1=16'h40B0, num2=16'h5058 -> 16'h5517, precisionLost=1.
- Subnormal×normal: num1=16'h00E0, num2=16'h5060 -> 16'h0FA8, exact. Subnormal×subnormal: num1=16'h00B8, num2=16'h0080 -> 16'h0000, zero=1, precisionLost=1.
- Specials:
  - num1=16'h40B0, num2=16'h7C00 -> 16'h7C00, overflow=0.
  - num1=16'h40B0, num2=16'h0000 -> 16'h0000, zero=1.
  - 16'h7C00 × 16'h0000 -> 16'h7E00, nan=1.
- Overflow: num1=16'h7BFF, num2=16'h4000 -> 16'h7C00, overflow=1, precisionLost=1.
- Reset/hold:
  - Assert rst_n=0 mid-stream -> all outputs 0 next edge.
  - With valid_in=0 and changing operands -> result holds, valid_out=0.

Source files
------------

// File: rtl/float_multi_fp16.sv
// IEEE-754 binary16 multiplier with round-to-nearest-even and status flags.
// The result and flags are registered, so latency is one cycle and one
// operation can be issued every cycle.
// Ports:
//   clk, rst_n     rising-edge clock, synchronous active-low reset
//   valid_in       num1/num2 are valid this cycle
//   num1, num2     operands {sign, exp[4:0], frac[9:0]}, bias 15
//   valid_out      valid_in delayed by one cycle
//   result         rounded product
//   overflow       finite operands overflowed to +/-inf
//   zero           result magnitude is 0
//   nan            result is the canonical NaN 16'h7E00
//   precisionLost  nonzero bits were discarded (inexact), or overflow
module float_multi_fp16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [15:0] num1,
  input  logic [15:0] num2,
  output logic        valid_out,
  output logic [15:0] result,
  output logic        overflow,
  output logic        zero,
  output logic        nan,
  output logic        precisionLost
);

  localparam int unsigned SIG_W  = 11;
  localparam int unsigned PROD_W = 2 * SIG_W;

  logic              sign_c;
  logic [4:0]        e1, e2;
  logic [9:0]        f1, f2;
  logic              nan1, nan2, inf1, inf2, zero1, zero2;
  logic [SIG_W-1:0]  sig1, sig2;
  logic [4:0]        ee1, ee2;
  logic [PROD_W-1:0] prod, norm, den;
  logic [4:0]        msb;
  logic signed [7:0] exp_n;
  logic [7:0]        sh;
  logic [4:0]        sh_c;
  logic [4:0]        e_field;
  logic              lost, g, r, st, up;
  logic [14:0]       mag;
  logic [15:0]       res_c;
  logic              ovf_c, zero_c, nan_c, pl_c;

  // Operand decode, significand product and rounding.
  always_comb begin
    sign_c  = num1[15] ^ num2[15];
    e1      = num1[14:10];
    e2      = num2[14:10];
    f1      = num1[9:0];
    f2      = num2[9:0];
    nan1    = (e1 == 5'd31) && (f1 != 10'd0);
    nan2    = (e2 == 5'd31) && (f2 != 10'd0);
    inf1    = (e1 == 5'd31) && (f1 == 10'd0);
    inf2    = (e2 == 5'd31) && (f2 == 10'd0);
    zero1   = (e1 == 5'd0) && (f1 == 10'd0);
    zero2   = (e2 == 5'd0) && (f2 == 10'd0);
    sig1    = {(e1 != 5'd0), f1};
    sig2    = {(e2 != 5'd0), f2};
    // Subnormals share the exponent of the smallest normal.
    ee1     = (e1 == 5'd0) ? 5'd1 : e1;
    ee2     = (e2 == 5'd0) ? 5'd1 : e2;
    prod    = PROD_W'(sig1) * PROD_W'(sig2);

    msb = 5'd0;
    for (int i = 0; i < int'(PROD_W); i++) begin
      if (prod[i]) msb = 5'(i);
    end

    // Biased exponent of the product once its leading one sits at bit 21.
    exp_n   = 8'(ee1) + 8'(ee2) + 8'(msb) - 8'd35;
    norm    = prod << (5'd21 - msb);

    sh      = 8'd0;
    sh_c    = 5'd0;
    den     = norm;
    lost    = 1'b0;
    e_field = 5'd0;
    if (exp_n < 8'sd1) begin
      // Denormalize; a shift of 22 or more clears everything into sticky.
      sh   = 8'd1 - exp_n;
      sh_c = (sh > 8'd22) ? 5'd22 : sh[4:0];
      den  = norm >> sh_c;
      lost = |(norm & ~(22'h3FFFFF << sh_c));
    end else begin
      // Hidden bit is added back below, so store exponent minus one.
      e_field = exp_n[4:0] - 5'd1;
    end

    g   = den[10];
    r   = den[9];
    st  = (|den[8:0]) | lost;
    up  = g & (r | st | den[11]);
    // Mantissa carry ripples into the exponent, including subnormal -> normal.
    mag = {e_field, 10'd0} + 15'(den[21:11]) + 15'(up);

    res_c  = {sign_c, mag};
    ovf_c  = 1'b0;
    zero_c = 1'b0;
    nan_c  = 1'b0;
    pl_c   = g | r | st;

    if (exp_n >= 8'sd31 || mag >= 15'h7C00) begin
      res_c = {sign_c, 15'h7C00};
      ovf_c = 1'b1;
      pl_c  = 1'b1;
    end else if (mag == 15'd0) begin
      zero_c = 1'b1;
    end

    // Special operands override the finite path, highest priority first.
    if (nan1 || nan2 || (inf1 && zero2) || (zero1 && inf2)) begin
      res_c  = 16'h7E00;
      ovf_c  = 1'b0;
      zero_c = 1'b0;
      nan_c  = 1'b1;
      pl_c   = 1'b0;
    end else if (inf1 || inf2) begin
      res_c  = {sign_c, 15'h7C00};
      ovf_c  = 1'b0;
      zero_c = 1'b0;
      pl_c   = 1'b0;
    end else if (zero1 || zero2) begin
      res_c  = {sign_c, 15'h0000};
      ovf_c  = 1'b0;
      zero_c = 1'b1;
      pl_c   = 1'b0;
    end
  end

  // Output registers: capture on valid_in, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_out     <= 1'b0;
      result        <= 16'd0;
      overflow      <= 1'b0;
      zero          <= 1'b0;
      nan           <= 1'b0;
      precisionLost <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        result        <= res_c;
        overflow      <= ovf_c;
        zero          <= zero_c;
        nan           <= nan_c;
        precisionLost <= pl_c;
      end
    end
  end

endmodule

// File: tb/tb_float_multi_fp16.sv
module tb_float_multi_fp16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [15:0] num1, num2;
  logic        valid_out;
  logic [15:0] result;
  logic        overflow, zero, nan, precisionLost;

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  float_multi_fp16 dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .num1(num1), .num2(num2),
    .valid_out(valid_out), .result(result), .overflow(overflow), .zero(zero),
    .nan(nan), .precisionLost(precisionLost)
  );

  always #5 clk = ~clk;

  // Reference product from exact integer arithmetic: value = P * 2^X,
  // rounded to a multiple of the result ulp 2^q. Returns {result, ovf, zero, nan, pl}.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b);
    int ea = int'(a[14:10]);
    int eb = int'(b[14:10]);
    int fa = int'(a[9:0]);
    int fb = int'(b[9:0]);
    logic s = a[15] ^ b[15];
    bit an = (ea == 31) && (fa != 0);
    bit bn = (eb == 31) && (fb != 0);
    bit ai = (ea == 31) && (fa == 0);
    bit bi = (eb == 31) && (fb == 0);
    bit az = (ea == 0) && (fa == 0);
    bit bz = (eb == 0) && (fb == 0);
    longint p, n, rem, half;
    int x, m, l, q, k, biased;
    if (an || bn || (ai && bz) || (az && bi)) return {16'h7E00, 4'b0010};
    if (ai || bi) return {s, 15'h7C00, 4'b0000};
    if (az || bz) return {s, 15'h0000, 4'b0100};
    p = longint'((ea == 0) ? fa : fa + 1024) * longint'((eb == 0) ? fb : fb + 1024);
    x = ((ea == 0) ? 1 : ea) + ((eb == 0) ? 1 : eb) - 50;
    m = 0;
    for (int i = 0; i < 24; i++) if (p >= (64'sd1 <<< i)) m = i;
    l = m + x;
    q = (l - 10 > -24) ? l - 10 : -24;
    k = q - x;
    rem = 0;
    if (k <= 0) begin
      n = p <<< (-k);
    end else begin
      n    = p >>> k;
      rem  = p - (n <<< k);
      half = 64'sd1 <<< (k - 1);
      if (rem > half || (rem == half && n[0])) n = n + 1;
    end
    if (n == 2048) begin
      n = 1024;
      q = q + 1;
    end
    if (n == 0) return {s, 15'h0000, 4'b0101};
    if (n < 1024) return {s, 15'(n), 3'b000, rem != 0};
    biased = q + 25;
    if (biased >= 31) return {s, 15'h7C00, 4'b1001};
    return {s, 5'(biased), 10'(n - 1024), 3'b000, rem != 0};
  endfunction

  // Expected register state, advanced from the model each clock.
  logic [20:0] exp_q;
  always @(posedge clk) begin
    if (!rst_n)        exp_q <= 21'd0;
    else if (valid_in) exp_q <= {1'b1, model(num1, num2)};
    else               exp_q <= {1'b0, exp_q[19:0]};
  end

  function automatic logic [20:0] dut_vec();
    return {valid_out, result, overflow, zero, nan, precisionLost};
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (armed) begin
      total++;
      if (dut_vec() !== exp_q) begin
        bad++;
        $display("FAIL model_cmp a=%h b=%h got v/res/flags=%b/%h/%b want %b/%h/%b",
                 num1, num2, valid_out, result, dut_vec() & 21'hF,
                 exp_q[20], exp_q[19:4], exp_q[3:0]);
      end
    end
  end

  task automatic check(input string name, input logic [20:0] want);
    total++;
    if (dut_vec() !== want) begin
      bad++;
      $display("FAIL %s got v/res/flags=%b/%h/%b want %b/%h/%b", name,
               valid_out, result, dut_vec() & 21'hF, want[20], want[19:4], want[3:0]);
    end
  endtask

  // Apply one operand pair, then check the registered outcome one cycle later.
  task automatic apply(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] want_res, input logic [3:0] want_flags);
    num1 = a;
    num2 = b;
    valid_in = 1'b1;
    @(negedge clk);
    check(name, {1'b1, want_res, want_flags});
  endtask

  typedef struct {
    string       name;
    logic [15:0] a, b, res;
    logic [3:0]  flags;  // {overflow, zero, nan, precisionLost}
  } vec_t;

  vec_t vecs[$] = '{
    '{"inexact",      16'h54A5, 16'h10CC, 16'h2992, 4'b0001},
    '{"exact_neg",    16'hC0B0, 16'h1CC0, 16'hA191, 4'b0000},
    '{"inexact2",     16'h40B0, 16'h5058, 16'h5517, 4'b0001},
    '{"sub_x_norm",   16'h00E0, 16'h5060, 16'h0FA8, 4'b0000},
    '{"sub_x_sub",    16'h00B8, 16'h0080, 16'h0000, 4'b0101},
    '{"fin_x_inf",    16'h40B0, 16'h7C00, 16'h7C00, 4'b0000},
    '{"fin_x_zero",   16'h40B0, 16'h0000, 16'h0000, 4'b0100},
    '{"inf_x_zero",   16'h7C00, 16'h0000, 16'h7E00, 4'b0010},
    '{"overflow",     16'h7BFF, 16'h4000, 16'h7C00, 4'b1001},
    '{"one_x_one",    16'h3C00, 16'h3C00, 16'h3C00, 4'b0000},
    '{"tie_even_0",   16'h0001, 16'h3800, 16'h0000, 4'b0101},
    '{"sub_round_up", 16'h0001, 16'h3E00, 16'h0002, 4'b0001},
    '{"norm_to_sub",  16'h0400, 16'h3800, 16'h0200, 4'b0000},
    '{"sub_to_norm",  16'h03FF, 16'h3C01, 16'h0400, 4'b0001},
    '{"rnd_carry",    16'h3DA7, 16'h3DA9, 16'h4000, 4'b0001},
    '{"rnd_ovf",      16'h59A7, 16'h5DA9, 16'h7C00, 4'b1001},
    '{"nan_in",       16'h7E00, 16'h3C00, 16'h7E00, 4'b0010},
    '{"ninf_x_ninf",  16'hFC00, 16'hFC00, 16'h7C00, 4'b0000},
    '{"negzero",      16'h8000, 16'h3C00, 16'h8000, 4'b0100},
    '{"sub_x2",       16'h03FF, 16'h4000, 16'h07FE, 4'b0000}
  };

  initial begin
    rst_n = 1'b0;
    valid_in = 1'b0;
    num1 = 16'h0000;
    num2 = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    armed = 1'b1;
    check("reset_state", 21'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flags);

    // Hold: operands change while valid_in is low.
    valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      num1 = 16'h4400 + 16'(i);
      num2 = 16'hC200;
      @(negedge clk);
      check("hold", {1'b0, 16'h07FE, 4'b0000});
    end

    apply("post_hold", 16'h54A5, 16'h10CC, 16'h2992, 4'b0001);

    // Synchronous reset mid-stream with valid_in still high.
    num1 = 16'h7BFF;
    num2 = 16'h4000;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_reset", 21'd0);
    rst_n = 1'b1;

    // Pseudo-random back-to-back traffic, checked by the model every cycle.
    for (int i = 0; i < 300; i++) begin
      num1 = 16'($urandom);
      num2 = 16'($urandom);
      valid_in = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
